// File: rtl/fpadd_shift_pkg.sv
// rtl/fpadd_shift_pkg.sv - shared types and widths for the fpadd alignment-shift arbiter
//
// Purpose: significand/shift widths, source id type and the request/response
// records that travel through the two pipeline stages.
// Ports: none (package).

package fpadd_shift_pkg;

    localparam int SIG_W     = 57;
    localparam int SHAMT_W   = 6;
    // Tag field is sized for the widest supported tag; narrower tags are
    // zero-extended on entry and truncated on exit.
    localparam int TAG_MAX_W = 16;

    typedef logic src_t;

    typedef struct packed {
        logic [SIG_W-1:0]     a;
        logic [SHAMT_W-1:0]   shift;
        logic [TAG_MAX_W-1:0] tag;
    } shift_req_t;

    typedef struct packed {
        logic [SIG_W-1:0]     z;
        logic                 sticky;
        logic [TAG_MAX_W-1:0] tag;
    } shift_rsp_t;

endpackage

// File: rtl/barrel_shifter_r57.sv
// rtl/barrel_shifter_r57.sv - 57-bit logarithmic right shifter with sticky
//
// Purpose: z = a >> shift (zero fill), sticky = OR of every bit shifted out.
// Ports:
//   a      in  57  significand
//   shift  in  6   shift amount 0..63
//   z      out 57  shifted significand
//   sticky out 1   OR of discarded bits

import fpadd_shift_pkg::*;

module barrel_shifter_r57 (
    input  logic [SIG_W-1:0]   a,
    input  logic [SHAMT_W-1:0] shift,
    output logic [SIG_W-1:0]   z,
    output logic               sticky
);

    logic [SIG_W-1:0] lvl [0:SHAMT_W];
    logic             stk [0:SHAMT_W];

    assign lvl[0] = a;
    assign stk[0] = 1'b0;

    // Stage i shifts by 2**i. Amounts past the width simply empty the
    // vector, so shifts of 57..63 give z = 0 with sticky = |a.
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int               AMT  = 1 << i;
        localparam logic [SIG_W-1:0] MASK = (SIG_W'(1) << AMT) - SIG_W'(1);

        assign lvl[i+1] = shift[i] ? (lvl[i] >> AMT) : lvl[i];
        assign stk[i+1] = stk[i] | (shift[i] & (|(lvl[i] & MASK)));
    end

    assign z      = lvl[SHAMT_W];
    assign sticky = stk[SHAMT_W];

endmodule

// File: rtl/fpadd_shift_arb.sv
// rtl/fpadd_shift_arb.sv - round-robin arbiter and 2-stage pipeline around a shared alignment shifter
//
// Purpose: accepts one shift request per cycle from two fpadd lanes, shifts it
// through barrel_shifter_r57 and returns {z, sticky, src, tag} on a
// valid/ready output driven straight from the S2 registers.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   req{0,1}_valid/ready             request handshake per source
//   req{0,1}_a/shift/tag             significand, shift amount, opaque tag
//   out_valid/out_ready              result handshake
//   out_z/out_sticky/out_src/out_tag result fields

import fpadd_shift_pkg::*;

module fpadd_shift_arb #(
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [SIG_W-1:0]   req0_a,
    input  logic [SHAMT_W-1:0] req0_shift,
    input  logic [TAG_W-1:0]   req0_tag,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [SIG_W-1:0]   req1_a,
    input  logic [SHAMT_W-1:0] req1_shift,
    input  logic [TAG_W-1:0]   req1_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SIG_W-1:0]   out_z,
    output logic               out_sticky,
    output logic               out_src,
    output logic [TAG_W-1:0]   out_tag
);

    logic       s1_valid;
    shift_req_t s1_req;
    src_t       s1_src;

    logic       s2_valid;
    shift_rsp_t s2_rsp;
    src_t       s2_src;

    logic       last_grant;

    logic       s1_adv;
    logic       s2_adv;
    logic       grant0;
    logic       grant1;
    logic       acc0;
    logic       acc1;
    shift_req_t win_req;
    src_t       win_src;

    logic [SIG_W-1:0] sh_z;
    logic             sh_sticky;

    assign s2_adv = !s2_valid || out_ready;
    assign s1_adv = !s1_valid || s2_adv;

    // Grants are formed from the other source's valid only, so a source's
    // ready never depends on its own valid. With neither valid both grants
    // are high, which is harmless because nothing is accepted.
    assign grant0 = !req1_valid || last_grant;
    assign grant1 = !req0_valid || !last_grant;

    assign req0_ready = s1_adv && grant0;
    assign req1_ready = s1_adv && grant1;

    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;

    always_comb begin
        win_req = '0;
        win_src = src_t'(1'b0);
        if (acc1) begin
            win_req.a     = req1_a;
            win_req.shift = req1_shift;
            win_req.tag   = TAG_MAX_W'(req1_tag);
            win_src       = src_t'(1'b1);
        end else begin
            win_req.a     = req0_a;
            win_req.shift = req0_shift;
            win_req.tag   = TAG_MAX_W'(req0_tag);
        end
    end

    barrel_shifter_r57 u_shifter (
        .a      (s1_req.a),
        .shift  (s1_req.shift),
        .z      (sh_z),
        .sticky (sh_sticky)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_req     <= '0;
            s1_src     <= src_t'(1'b0);
            s2_valid   <= 1'b0;
            s2_rsp     <= '0;
            s2_src     <= src_t'(1'b0);
            last_grant <= 1'b1;
        end else begin
            // S2 drain and S1 refill may both happen in one cycle.
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_rsp.z      <= sh_z;
                    s2_rsp.sticky <= sh_sticky;
                    s2_rsp.tag    <= s1_req.tag;
                    s2_src        <= s1_src;
                end
            end

            if (s1_adv) begin
                s1_valid <= acc0 || acc1;
                if (acc0 || acc1) begin
                    s1_req <= win_req;
                    s1_src <= win_src;
                end
            end

            if (acc0) begin
                last_grant <= 1'b0;
            end else if (acc1) begin
                last_grant <= 1'b1;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_z      = s2_rsp.z;
    assign out_sticky = s2_rsp.sticky;
    assign out_src    = s2_src;
    assign out_tag    = s2_rsp.tag[TAG_W-1:0];

    // Upper tag bits beyond TAG_W are always zero and intentionally dropped.
    logic unused_tag_bits;
    assign unused_tag_bits = ^s2_rsp.tag;

endmodule

// File: doc/fpadd_shift_arb.md
# fpadd_shift_arb

Two-requester arbiter and pipeline controller that shares a single 57-bit right alignment shifter (`barrel_shifter_r57`) between two fpadd significand-alignment sources. It accepts one shift request per cycle under round-robin priority, carries each operation through a two-stage registered pipeline, and returns the shifted significand, sticky bit, source ID and tag on a valid/ready output. It sits between the exponent-compare logic of the two adder lanes and the shared alignment datapath.

## Interface
- `TAG_W`, default 4: width of the opaque per-request tag, returned unchanged.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req0_valid`, `req1_valid` input 1: request present from source 0 / source 1.
- `req0_ready`, `req1_ready` output 1: request accepted this cycle when ready and valid are both high.
- `req0_a`, `req1_a` input 57: significand to right-shift.
- `req0_shift`, `req1_shift` input 6: right-shift amount, 0..63.
- `req0_tag`, `req1_tag` input TAG_W: opaque tag.
- `out_valid` output 1: result present.
- `out_ready` input 1: downstream accepts result.
- `out_z` output 57: `A >> shift`, zero-filled.
- `out_sticky` output 1: OR of all bits shifted out.
- `out_src` output 1: source that issued the result.
- `out_tag` output TAG_W: tag of that request.

## Operation
- Pipeline stages:
  - S1 registers the winning request's {a, shift, src, tag}.
  - S2 registers the shifter result {z, sticky, src, tag}. The shifter reads the S1 registers combinationally.
- Advance rules:
  - `s2_adv = !s2_valid | out_ready`
  - `s1_adv = !s1_valid | s2_adv`
  - The request side accepts only when `s1_adv` is high.
- Arbitration uses round-robin with a 1-bit `last_grant` register.
  - Only one requester valid: it is granted.
  - Both valid: grant goes to `!last_grant`.
  - `reqN_ready = s1_adv & grantN`. Ready may depend on the other source's valid; it never depends on its own valid.
- `last_grant` updates only on an actual accept. No accept leaves it unchanged.
- Shift semantics:
  - Shift 0: `z = a`, sticky 0.
  - Shift 57..63: `z = 0`, sticky = `|a`.
- On stall (`out_ready` low with S2 full), S2 and all outputs hold stable. S1 holds if it is full. Data is never dropped or duplicated.
- `out_*` are driven directly from S2 registers. There is no combinational path from `req*` to `out_*`.
- Reset values:
  - S1 valid 0, S2 valid 0, `out_valid` 0.
  - `out_z` 0, `out_sticky` 0, `out_src` 0, `out_tag` 0.
  - `last_grant` 1, so source 0 has first priority.
- Asserting reset mid-operation discards all in-flight entries immediately. No result is emitted for them.

## Timing
- Latency: accept at edge N gives `out_valid` high after edge N+1. Two register stages.
- Throughput: one result per cycle while `out_ready` stays high.
- Both sources continuously valid, no backpressure: grants alternate 0,1,0,1…
- Backpressure:
  - The cycle `out_ready` drops with both stages full, `req*_ready` fall combinationally.
  - Acceptance resumes in the same cycle `out_ready` returns high.
- Simultaneous S2 drain and S1 refill in one cycle is legal and required. It is the full-throughput case.

## Structure
- Package `fpadd_shift_pkg` holds:
  - `SIG_W = 57` and `SHAMT_W = 6`.
  - The `shift_req_t` struct {a, shift, tag} and the `shift_rsp_t` struct {z, sticky, tag}.
  - The `src_t` typedef.
- Sub-module: one instance of the existing `barrel_shifter_r57` between S1 and S2. Arbiter and pipeline-control logic stay flat in `fpadd_shift_arb`.

## Test plan
- **Single op**
  - Stimulus: req0 with a=57'h1FF, shift=4, tag=3.
  - Response: 2 cycles later, z=57'h1F, sticky=1, src=0, tag=3.
  - Also: a=57'h100, shift=8 gives z=57'h1, sticky=0.
- **Saturation**
  - Stimulus: a=57'h1, shift=63.
  - Response: z=0, sticky=1.
  - Also: a=0, shift=63 gives z=0, sticky=0. Shift=0 returns a unchanged with sticky 0.
- **Round-robin**
  - Stimulus: both sources valid for 6 cycles from reset, tags 0..5 per source, out_ready=1.
  - Response: outputs alternate src 0,1,0,1,0,1. No starvation. Tags come out in per-source order.
- **Backpressure**
  - Stimulus: stream from req0, out_ready low for 3 cycles mid-stream.
  - Response: out_* are stable during the stall and both ready signals are low. The sequence shows no loss or duplicate, and full rate resumes on release.
- **Reset mid-flight**
  - Stimulus: drop reset_n with S1 and S2 full.
  - Response: out_valid is 0 asynchronously. After release, the first accepted request wins by source 0 priority and no stale result appears.
- **Random**
  - Stimulus: random valid/ready/a/shift for 10k cycles.
  - Response: scoreboard matches `a >> shift` and sticky against a reference model, with per-source ordering preserved.
